// File: rtl/fir_coef_ctrl.sv
// Coefficient bank sequencer for the transposed-form FIR chain: shadow/active banks, atomic swap,
// enable and valid generation. Define FIR_CTRL_ZERO_FLUSH_EN to flush L zero samples after each swap.
module fir_coef_ctrl #(
    parameter int ORDER    = 1,
    parameter int COEF_W   = 18,
    parameter int COEF_RST = 123,
    parameter int ADDR_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        filt_ena,
    output logic                        x_zero,
    output logic                        dout_valid,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ADDR_W-1:0]           cfg_addr,
    input  logic [COEF_W-1:0]           cfg_data,
    input  logic                        cfg_commit,
    output logic                        commit_done,
    output logic                        busy,
    output logic [(ORDER+1)*COEF_W-1:0] coef_out
);
    // state     | meaning
    // ST_RUN    | normal streaming, samples accepted, commit requests start a swap
    // ST_SWAP   | one cycle: shadow copied to active, token history cleared
    // ST_FLUSH  | L cycles of zero input to purge pre-swap history (macro builds only)

    localparam int NTAP  = ORDER + 1;
    localparam int L     = ORDER + 2;
    localparam int TOK_W = L - 1;
    localparam logic [COEF_W-1:0] COEF_RST_V = COEF_W'(COEF_RST);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SWAP  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_pending;
    // Only the bits that feed dout_valid are kept; the oldest token bit is never observed.
    logic [TOK_W-1:0]  r_tok;
    logic [COEF_W-1:0] r_shadow [NTAP];
    logic [COEF_W-1:0] r_active [NTAP];

`ifdef FIR_CTRL_ZERO_FLUSH_EN
    localparam int CNT_W = $clog2(L + 1);
    logic [CNT_W-1:0]  r_cnt;
`endif

    logic w_accept;
    logic w_cfg_wr;
    logic w_start;

    assign s_ready   = rst & (r_state == ST_RUN);
    assign cfg_ready = rst & (r_state != ST_SWAP);
    assign busy      = rst & ((r_state != ST_RUN) | r_pending);
    assign w_accept  = s_valid & s_ready;
    assign w_cfg_wr  = cfg_valid & cfg_ready;
    assign w_start   = (r_state == ST_RUN) & (r_pending | cfg_commit);

`ifdef FIR_CTRL_ZERO_FLUSH_EN
    assign x_zero    = rst & (r_state == ST_FLUSH);
    assign filt_ena  = w_accept | x_zero;
`else
    assign x_zero    = 1'b0;
    assign filt_ena  = w_accept;
`endif

    always_comb begin
        coef_out = '0;
        for (int i = 0; i < NTAP; i++) begin
            coef_out[i*COEF_W +: COEF_W] = r_active[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_pending   <= 1'b0;
            r_tok       <= '0;
            dout_valid  <= 1'b0;
            commit_done <= 1'b0;
`ifdef FIR_CTRL_ZERO_FLUSH_EN
            r_cnt       <= '0;
`endif
            for (int i = 0; i < NTAP; i++) begin
                r_shadow[i] <= COEF_RST_V;
                r_active[i] <= COEF_RST_V;
            end
        end else begin
            commit_done <= 1'b0;
            dout_valid  <= filt_ena & r_tok[TOK_W-1];

            if (filt_ena) begin
                r_tok <= (r_tok << 1) | TOK_W'(w_accept);
            end

            // Commits arriving while busy are held; repeated ones collapse into the one flag.
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (cfg_commit) begin
                r_pending <= 1'b1;
            end

            // Addresses above ORDER match no tap and are silently dropped.
            if (w_cfg_wr) begin
                for (int i = 0; i < NTAP; i++) begin
                    if (cfg_addr == ADDR_W'(i)) begin
                        r_shadow[i] <= cfg_data;
                    end
                end
            end

            case (r_state)
                ST_RUN: begin
                    if (w_start) begin
                        r_state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    for (int i = 0; i < NTAP; i++) begin
                        r_active[i] <= r_shadow[i];
                    end
                    r_tok <= '0;
`ifdef FIR_CTRL_ZERO_FLUSH_EN
                    r_cnt   <= CNT_W'(L - 1);
                    r_state <= ST_FLUSH;
`else
                    r_state     <= ST_RUN;
                    commit_done <= 1'b1;
`endif
                end
`ifdef FIR_CTRL_ZERO_FLUSH_EN
                ST_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_RUN;
                        commit_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: doc/fir_coef_ctrl.md
# fir_coef_ctrl

Coefficient and enable sequencer for the transposed-form FIR chain built from `filter_block_step` stages. It holds a host-writable shadow coefficient bank and an active bank that drives the filter's `b` inputs. On request it swaps the shadow bank into the active bank atomically. It also generates the filter's `ena`, and optionally a zero-input flush, so that no output mixing old and new coefficients is flagged valid.

## Interface
- `ORDER`, 1: filter order; ORDER+1 taps.
- `COEF_W`, 18: coefficient width, signed.
- `COEF_RST`, 123: reset value of every shadow and active coefficient.
- `ADDR_W`, 4: width of the coefficient address; requires 2**ADDR_W ≥ ORDER+1.
- Derived L = ORDER+2: filter latency in enables (input sync register plus ORDER+1 stages).

Ports:
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  an input sample is presented to the filter this cycle.
- `s_ready`  out  1  the controller accepts the sample; s_ready = rst & (state==RUN).
- `filt_ena`  out  1  filter chain enable.
- `x_zero`  out  1  the filter input mux selects 0 instead of the sample.
- `dout_valid`  out  1  registered one-cycle pulse marking a valid filter `dout`.
- `cfg_valid`  in  1  coefficient write request.
- `cfg_ready`  out  1  write accepted when cfg_valid & cfg_ready.
- `cfg_addr`  in  ADDR_W  tap index.
- `cfg_data`  in  COEF_W  signed coefficient.
- `cfg_commit`  in  1  single-cycle request to swap shadow→active.
- `commit_done`  out  1  registered one-cycle pulse when the swap sequence completes.
- `busy`  out  1  state≠RUN or a commit is pending.
- `coef_out`  out  (ORDER+1)*COEF_W  active bank, packed; tap i is at [i*COEF_W +: COEF_W].

## Operation
- FSM states: RUN, SWAP, FLUSH (FLUSH exists only with the macro). Reset state is RUN.
- RUN:
  - filt_ena = s_valid & s_ready; x_zero = 0.
- SWAP, exactly one cycle:
  - s_ready, filt_ena and cfg_ready are 0.
  - At the end of the cycle, active bank <= shadow bank and the token register is cleared.
- FLUSH, exactly L cycles, counted by a down-counter:
  - filt_ena = 1, x_zero = 1, s_ready = 0.
- Coefficient writes:
  - cfg_ready = rst & (state≠SWAP).
  - An accepted write with cfg_addr ≤ ORDER updates shadow[cfg_addr] at the end of the cycle.
  - An out-of-range address is accepted and dropped.
  - The active bank changes only at the end of SWAP.
- Commit:
  - cfg_commit sets a pending flag.
  - The FSM enters SWAP from RUN on the cycle after the flag is set, or the cycle after returning to RUN.
  - A commit received outside RUN is held; it is not lost.
  - Multiple commits while pending collapse into one.
  - A write and a commit in the same cycle: the write is included in the swap.
- Token register `tok`, L bits:
  - Shifts on filt_ena; shift-in bit = s_valid & s_ready.
  - dout_valid <= filt_ena & tok[L-2].
  - Zeros shifted in during FLUSH, or the clear in SWAP, guarantee that no output computed from pre-swap samples is flagged valid.
- Reset, asserted at any time including mid-SWAP/FLUSH:
  - Returns to RUN and clears the pending flag, tok, dout_valid and commit_done.
  - Shadow and active banks return to COEF_RST.
  - While rst is low, every combinational output is 0 (including s_ready and cfg_ready); coef_out = COEF_RST for all taps.

## Timing
- Commit pulse at cycle T while in RUN with nothing pending:
  - SWAP at T+1.
  - FLUSH at T+2..T+1+L.
  - RUN at T+2+L; commit_done = 1 in T+2+L.
- Without the macro: SWAP at T+1; RUN and commit_done at T+2.
- coef_out changes in the cycle after SWAP.
- Sample latency: a sample accepted at the k-th filt_ena produces a dout_valid pulse in the cycle after the (k+L-1)-th filt_ena.
- Back-to-back accepted samples give a continuous dout_valid after an L-cycle fill.

## Configuration
- `FIR_CTRL_ZERO_FLUSH_EN` defined: the FLUSH state is present. The chain is flushed with L zero samples after every swap, so post-swap outputs use zero history.
- Not defined: no FLUSH state; x_zero is tied to 0. After the swap, the first L accepted samples produce no dout_valid (stale history is discarded via the tok clear).

## Test plan
- Reset → coef_out = {123,123}, dout_valid = 0, busy = 0, s_ready = 1 once rst is high.
- ORDER=1: s_valid held high from cycle 0 → dout_valid first high at cycle 3, then every cycle.
- Write addr 0 = −5, addr 1 = 7, commit at T → coef_out = {7,−5} from T+2; commit_done at T+5 (macro) or T+2 (no macro).
- Macro on: commit mid-stream → x_zero = filt_ena = 1 for exactly 3 cycles and s_ready = 0 for 4 cycles. Without the macro, no dout_valid for 3 accepted samples after the swap.
- Commit during FLUSH, plus a write in the commit cycle → second swap follows immediately after return to RUN and includes the written value; cfg_addr = 9 is accepted and leaves all taps unchanged.
- rst asserted in FLUSH → next cycle state RUN, coef_out = {123,123}, pending cleared, no commit_done.
